// File: rtl/ahb_spi_pkg.sv
// Shared definitions for the AHB-Lite SPI master.
// Holds the register word offsets, CTRL/STATUS bit positions, CTRL field
// widths, the transfer FSM state encoding and the bit-order helper used to
// map a transmit/receive ordinal onto a bit position in the frame.
package ahb_spi_pkg;

  // Register word offsets (HADDR[4:2]).
  localparam logic [2:0] REG_TXDATA = 3'd0;
  localparam logic [2:0] REG_RXDATA = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;
  localparam logic [2:0] REG_DIV    = 3'd3;
  localparam logic [2:0] REG_CSREG  = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;

  // CTRL bit positions and field widths.
  localparam int CTRL_CPOL      = 0;
  localparam int CTRL_CPHA      = 1;
  localparam int CTRL_LSBF      = 2;
  localparam int CTRL_AUTOCS    = 3;
  localparam int CTRL_IRQ_EN    = 4;
  localparam int CTRL_CSSEL_LSB = 8;
  localparam int CTRL_LEN_LSB   = 16;
  localparam int CSSEL_W        = 3;
  localparam int LEN_W          = 5;

  // STATUS bit positions.
  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;
  localparam int STAT_OVR   = 2;
  localparam int STAT_RXOVF = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_TRAIL = 2'd3
  } spi_state_e;

  // Position within the frame of the idx-th bit on the wire.
  // MSB-first starts at LEN-1, LSB-first starts at 0.
  function automatic logic [LEN_W-1:0] bit_pos(input logic [LEN_W-1:0] idx,
                                               input logic [LEN_W-1:0] len_m1,
                                               input logic             lsbf);
    return lsbf ? idx : (len_m1 - idx);
  endfunction

endpackage

// File: rtl/ahb_spi_master_tick_gen.sv
// spi_tick_gen: half-period timebase for the SPI master.
// A DIV_W-bit down-counter that reloads with div on restart or on reaching
// zero, and emits a one-cycle tick every div+1 cycles. After a restart the
// first tick arrives div+1 cycles later, so every transfer starts on a fresh
// half-period.
// Ports:
//   HCLK, HRESETn  clock, asynchronous active-low reset
//   restart        synchronous reload (transfer start)
//   div            half-period length minus one
//   tick           one-cycle pulse at the end of each half-period
module spi_tick_gen #(
  parameter int DIV_W = 8
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= div;
    end else if (cnt == '0) begin
      cnt <= div;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0) && !restart;

endmodule

// File: rtl/ahb_spi_master.sv
// ahb_spi_master: AHB-Lite slave SPI master.
// Programmable frame length (1..DATA_W bits), SCLK divider, all four
// CPOL/CPHA modes, MSB/LSB-first, NUM_CS chip selects with manual or
// automatic framing, sticky error flags and a level completion interrupt.
// Ports:
//   HCLK, HRESETn            bus clock, asynchronous active-low reset
//   HSEL..HWDATA             AHB-Lite slave inputs (only HADDR[4:2] decoded)
//   HRDATA, HREADYOUT        read data (zero-extended), always ready
//   MISO, MOSI, SCLK, CS_n   SPI pins, CS_n active low
//   IRQ                      IRQ_EN & DONE
//   dbg_state                current transfer FSM state (spi_state_e)
//
// Bus handshake: an address phase is accepted when HSEL & HTRANS[1] &
// HREADY; the slave never inserts wait states, so the following cycle is the
// data phase and register writes take effect on the edge that ends it.
module ahb_spi_master
  import ahb_spi_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 8
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic              HREADY,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [31:0]       HWDATA,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  input  logic              MISO,
  output logic              MOSI,
  output logic              SCLK,
  output logic [NUM_CS-1:0] CS_n,
  output logic              IRQ,
  output logic [1:0]        dbg_state
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DATA_W - 1);

  // Bus address-phase capture.
  logic       wr_q;
  logic       rd_q;
  logic [2:0] addr_q;

  // Registers.
  logic [DATA_W-1:0]  txdata;
  logic [DATA_W-1:0]  rxdata;
  logic               cpol, cpha, lsbf, autocs, irq_en;
  logic [CSSEL_W-1:0] cssel;
  logic [LEN_W-1:0]   len_m1;
  logic [DIV_W-1:0]   div_q;
  logic [NUM_CS-1:0]  csreg;
  logic               busy, done, ovr, rxovf;

  // Transfer engine.
  spi_state_e  state;
  logic [6:0]  edge_cnt;
  logic [31:0] rx_sr;
  logic        sclk_q, mosi_q;
  logic        tick;

  logic              start;
  logic              wr_tx;
  logic [6:0]        len2;
  logic              last_edge;
  logic              odd_edge;
  logic [LEN_W-1:0]  cur_idx;
  logic [LEN_W-1:0]  pos_cur;
  logic [LEN_W-1:0]  pos_next;
  logic [LEN_W-1:0]  pos_first;
  logic [31:0]       tx_ext;
  logic [LEN_W-1:0]  wlen;
  logic [31:0]       rdata;
  logic [NUM_CS-1:0] cs_n_c;
  logic              unused_ok;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      addr_q <= '0;
    end else if (HREADY) begin
      wr_q   <= HSEL & HTRANS[1] & HWRITE;
      rd_q   <= HSEL & HTRANS[1] & ~HWRITE;
      addr_q <= HADDR[4:2];
    end else begin
      // Another slave is stalling its data phase; ours has already ended.
      wr_q <= 1'b0;
      rd_q <= 1'b0;
    end
  end

  assign wr_tx = wr_q && (addr_q == REG_TXDATA);
  assign start = wr_tx && !busy;

  // Edge e (1..2*LEN) is being taken when edge_cnt == e-1.
  assign len2      = {1'b0, len_m1, 1'b0} + 7'd2;
  assign last_edge = (edge_cnt + 7'd1) == len2;
  assign odd_edge  = ~edge_cnt[0];
  assign cur_idx   = edge_cnt[5:1];
  assign pos_cur   = bit_pos(cur_idx, len_m1, lsbf);
  assign pos_next  = bit_pos(cur_idx + 5'd1, len_m1, lsbf);
  assign pos_first = bit_pos('0, len_m1, lsbf);
  assign tx_ext    = 32'(txdata);
  assign wlen      = HWDATA[CTRL_LEN_LSB +: LEN_W];

  spi_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .restart (start),
    .div     (div_q),
    .tick    (tick)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      txdata   <= '0;
      rxdata   <= '0;
      cpol     <= 1'b0;
      cpha     <= 1'b0;
      lsbf     <= 1'b0;
      autocs   <= 1'b0;
      irq_en   <= 1'b0;
      cssel    <= '0;
      len_m1   <= '0;
      div_q    <= '0;
      csreg    <= '1;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovr      <= 1'b0;
      rxovf    <= 1'b0;
      state    <= S_IDLE;
      edge_cnt <= '0;
      rx_sr    <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
    end else begin
      // Register writes. Flag clears come first so that a set later in this
      // block on the same edge wins.
      if (wr_q) begin
        case (addr_q)
          REG_TXDATA: begin
            if (busy) ovr <= 1'b1;
            else      txdata <= HWDATA[DATA_W-1:0];
          end
          REG_CTRL: begin
            cpol   <= HWDATA[CTRL_CPOL];
            cpha   <= HWDATA[CTRL_CPHA];
            lsbf   <= HWDATA[CTRL_LSBF];
            autocs <= HWDATA[CTRL_AUTOCS];
            irq_en <= HWDATA[CTRL_IRQ_EN];
            cssel  <= HWDATA[CTRL_CSSEL_LSB +: CSSEL_W];
            len_m1 <= (wlen > LEN_MAX) ? LEN_MAX : wlen;
          end
          REG_DIV:   div_q <= HWDATA[DIV_W-1:0];
          REG_CSREG: csreg <= HWDATA[NUM_CS-1:0];
          REG_STATUS: begin
            if (HWDATA[STAT_OVR])   ovr   <= 1'b0;
            if (HWDATA[STAT_RXOVF]) rxovf <= 1'b0;
          end
          default: ;
        endcase
      end

      if (rd_q && (addr_q == REG_RXDATA)) done <= 1'b0;

      case (state)
        S_IDLE: begin
          sclk_q <= cpol;
          if (start) begin
            state    <= S_LEAD;
            busy     <= 1'b1;
            edge_cnt <= '0;
            rx_sr    <= '0;
            // txdata is loaded on this same edge, so take bit from HWDATA.
            mosi_q   <= HWDATA[pos_first];
          end
        end
        S_LEAD: begin
          if (tick) state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (tick) begin
            sclk_q   <= ~sclk_q;
            edge_cnt <= edge_cnt + 7'd1;
            if (odd_edge) begin
              if (cpha) mosi_q <= tx_ext[pos_cur];
              else      rx_sr[pos_cur] <= MISO;
            end else begin
              if (cpha)            rx_sr[pos_cur] <= MISO;
              else if (!last_edge) mosi_q <= tx_ext[pos_next];
            end
            if (last_edge) state <= S_TRAIL;
          end
        end
        S_TRAIL: begin
          if (tick) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            rxdata <= rx_sr[DATA_W-1:0];
            if (done) rxovf <= 1'b1;
            done   <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_q) begin
      case (addr_q)
        REG_TXDATA: rdata = 32'(txdata);
        REG_RXDATA: rdata = 32'(rxdata);
        REG_CTRL: begin
          rdata[CTRL_CPOL]                  = cpol;
          rdata[CTRL_CPHA]                  = cpha;
          rdata[CTRL_LSBF]                  = lsbf;
          rdata[CTRL_AUTOCS]                = autocs;
          rdata[CTRL_IRQ_EN]                = irq_en;
          rdata[CTRL_CSSEL_LSB +: CSSEL_W]  = cssel;
          rdata[CTRL_LEN_LSB +: LEN_W]      = len_m1;
        end
        REG_DIV:   rdata = 32'(div_q);
        REG_CSREG: rdata = 32'(csreg);
        REG_STATUS: begin
          rdata[STAT_BUSY]  = busy;
          rdata[STAT_DONE]  = done;
          rdata[STAT_OVR]   = ovr;
          rdata[STAT_RXOVF] = rxovf;
        end
        default: ;
      endcase
    end
  end

  // Automatic framing holds the selected CS low for the whole BUSY window;
  // a CSSEL beyond NUM_CS matches no output.
  always_comb begin
    cs_n_c = csreg;
    if (autocs) begin
      cs_n_c = '1;
      if (busy) begin
        for (int i = 0; i < NUM_CS; i++) begin
          if (cssel == CSSEL_W'(i)) cs_n_c[i] = 1'b0;
        end
      end
    end
  end

  assign HRDATA    = rdata;
  assign HREADYOUT = 1'b1;
  assign MOSI      = mosi_q;
  assign SCLK      = sclk_q;
  assign CS_n      = cs_n_c;
  assign IRQ       = irq_en & done;
  assign dbg_state = state;

  assign unused_ok = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], rx_sr};

endmodule

// File: tb/tb_ahb_spi_master.sv
module tb_ahb_spi_master;
  import ahb_spi_pkg::*;

  localparam int DATA_W = 16;
  localparam int NUM_CS = 4;
  localparam int DIV_W  = 8;

  logic              HCLK;
  logic              HRESETn;
  logic              HSEL;
  logic              HREADY;
  logic [31:0]       HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [31:0]       HWDATA;
  logic [31:0]       HRDATA;
  logic              HREADYOUT;
  logic              MISO;
  logic              MOSI;
  logic              SCLK;
  logic [NUM_CS-1:0] CS_n;
  logic              IRQ;
  logic [1:0]        dbg_state;

  // 0: MISO looped to MOSI, 1: tied high, 2: tied low
  logic [1:0] miso_mode;
  assign MISO = (miso_mode == 2'd0) ? MOSI : miso_mode[0];

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] exp_q[$];   // expected RXDATA per frame
  logic [0:0]  mosi_q[$];  // expected MOSI bit per sample edge

  // Current configuration as the bench programmed it.
  logic              cur_cpol, cur_cpha, cur_lsbf;
  int                cur_len, cur_div;
  logic [NUM_CS-1:0] cur_act;

  ahb_spi_master #(.DATA_W(DATA_W), .NUM_CS(NUM_CS), .DIV_W(DIV_W)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HREADY    (HREADY),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADYOUT (HREADYOUT),
    .MISO      (MISO),
    .MOSI      (MOSI),
    .SCLK      (SCLK),
    .CS_n      (CS_n),
    .IRQ       (IRQ),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ahb_write(input logic [2:0] word, input logic [31:0] data);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = 1'b1;
    HADDR  = {27'd0, word, 2'b00};
    step(1);
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HWDATA = data;
    step(1);
  endtask

  task automatic ahb_read(input logic [2:0] word, output logic [31:0] data);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = 1'b0;
    HADDR  = {27'd0, word, 2'b00};
    step(1);
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    data   = HRDATA;
    step(1);
  endtask

  task automatic read_check(input string tag, input logic [2:0] word, input logic [31:0] exp);
    logic [31:0] d;
    ahb_read(word, d);
    check(tag, d, exp);
  endtask

  task automatic cfg(input logic cpol, input logic cpha, input logic lsbf,
                     input logic autocs, input logic irq_en, input int cssel,
                     input int len, input int div);
    logic [31:0] c;
    c = '0;
    c[CTRL_CPOL]   = cpol;
    c[CTRL_CPHA]   = cpha;
    c[CTRL_LSBF]   = lsbf;
    c[CTRL_AUTOCS] = autocs;
    c[CTRL_IRQ_EN] = irq_en;
    c[CTRL_CSSEL_LSB +: CSSEL_W] = 3'(cssel);
    c[CTRL_LEN_LSB +: LEN_W]     = 5'(len - 1);
    ahb_write(REG_CTRL, c);
    ahb_write(REG_DIV, 32'(div));
    cur_cpol = cpol;
    cur_cpha = cpha;
    cur_lsbf = lsbf;
    cur_len  = len;
    cur_div  = div;
    cur_act  = (autocs && cssel < NUM_CS) ? ~(NUM_CS'(1) << cssel) : '1;
  endtask

  // Pushes expected MOSI bits and RX word, starts a frame, then watches the
  // pins for the full expected BUSY window plus a margin.
  task automatic frame(input string tag, input logic [31:0] tx);
    int          exp_busy, edges, cs_act, cs_bad;
    logic        prev;
    logic [31:0] mask;
    logic [0:0]  eb;
    mask = (cur_len == 32) ? '1 : ((32'd1 << cur_len) - 32'd1);
    for (int i = 0; i < cur_len; i++)
      mosi_q.push_back(tx[cur_lsbf ? i : cur_len - 1 - i]);
    case (miso_mode)
      2'd0:    exp_q.push_back(tx & mask);
      2'd1:    exp_q.push_back(mask);
      default: exp_q.push_back(32'd0);
    endcase
    exp_busy = (2 * cur_len + 2) * (cur_div + 1);
    edges  = 0;
    cs_act = 0;
    cs_bad = 0;
    check({tag, "_sclk_idle_before"}, 32'(SCLK), 32'(cur_cpol));
    prev = SCLK;
    ahb_write(REG_TXDATA, tx);
    for (int c = 0; c < exp_busy + 4; c++) begin
      if (c > 0) step(1);
      if (cur_act !== '1 && CS_n === cur_act) cs_act++;
      else if (CS_n !== '1) cs_bad++;
      if (SCLK !== prev) begin
        edges++;
        prev = SCLK;
        if (((edges % 2) == 1) == (cur_cpha == 1'b0) && mosi_q.size() > 0) begin
          eb = mosi_q.pop_front();
          check({tag, "_mosi_bit"}, 32'(MOSI), 32'(eb));
        end
      end
    end
    check({tag, "_sclk_edges"}, 32'(edges), 32'(2 * cur_len));
    check({tag, "_mosi_left"}, 32'(mosi_q.size()), 32'd0);
    check({tag, "_cs_other"}, 32'(cs_bad), 32'd0);
    if (cur_act !== '1) check({tag, "_busy_cycles"}, 32'(cs_act), 32'(exp_busy));
    check({tag, "_sclk_idle_after"}, 32'(SCLK), 32'(cur_cpol));
  endtask

  task automatic check_rx(input string tag);
    logic [31:0] d;
    ahb_read(REG_RXDATA, d);
    if (exp_q.size() > 0) begin
      check(tag, d, exp_q.pop_front());
    end else begin
      n_checks++;
      n_err++;
      $error("FAIL %s observed=0x%0h expected=<no queued frame>", tag, d);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] d;
    HRESETn   = 1'b0;
    HSEL      = 1'b0;
    HREADY    = 1'b1;
    HADDR     = '0;
    HTRANS    = 2'b00;
    HWRITE    = 1'b0;
    HWDATA    = '0;
    miso_mode = 2'd0;
    cur_cpol = 1'b0; cur_cpha = 1'b0; cur_lsbf = 1'b0;
    cur_len = 8; cur_div = 0; cur_act = '1;

    // Reset state.
    step(3);
    check("rst_sclk", 32'(SCLK), 32'd0);
    check("rst_mosi", 32'(MOSI), 32'd0);
    check("rst_cs_n", 32'(CS_n), 32'hF);
    check("rst_irq", 32'(IRQ), 32'd0);
    check("rst_hrdata", HRDATA, 32'd0);
    check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    HRESETn = 1'b1;
    step(1);
    read_check("rst_csreg", REG_CSREG, 32'hF);
    read_check("rst_ctrl", REG_CTRL, 32'h0);
    read_check("rst_div", REG_DIV, 32'h0);
    read_check("rst_status", REG_STATUS, 32'h0);
    read_check("rst_rxdata", REG_RXDATA, 32'h0);
    read_check("unmapped", 3'd6, 32'h0);

    // Mode 0, DIV=0, LEN=8, loopback.
    cfg(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8, 0);
    miso_mode = 2'd0;
    frame("m0", 32'hA5);
    read_check("m0_status", REG_STATUS, 32'h2);
    check_rx("m0_rx");
    read_check("m0_status_clr", REG_STATUS, 32'h0);

    // Mode 3, DIV=3, LEN=16, LSB-first, MISO high, CS 2.
    cfg(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2, 16, 3);
    check("m3_sclk_idle", 32'(SCLK), 32'd1);
    read_check("m3_ctrl_rb", REG_CTRL, 32'h000F_020F);
    miso_mode = 2'd1;
    frame("m3", 32'h8001);
    check_rx("m3_rx");

    // CSSEL beyond NUM_CS selects nothing.
    cfg(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5, 8, 0);
    miso_mode = 2'd0;
    frame("cs5", 32'h3C);
    check_rx("cs5_rx");

    // LEN field saturates at DATA_W-1.
    ahb_write(REG_CTRL, 32'h001F_0000);
    read_check("len_sat", REG_CTRL, 32'h000F_0000);

    // Manual chip selects, truncated write.
    ahb_write(REG_CSREG, 32'hFFFF_FFF5);
    check("csreg_pins", 32'(CS_n), 32'h5);
    read_check("csreg_rb", REG_CSREG, 32'h5);
    ahb_write(REG_CSREG, 32'hF);

    // OVR on write while busy, then RXOVF on a second unread frame.
    cfg(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8, 3);
    ahb_write(REG_TXDATA, 32'h5A);
    ahb_write(REG_TXDATA, 32'h12);
    step(80);
    read_check("ovr_status", REG_STATUS, 32'h6);
    read_check("ovr_txdata", REG_TXDATA, 32'h5A);
    frame("ovf", 32'h3C);
    read_check("rxovf_status", REG_STATUS, 32'hE);
    ahb_write(REG_STATUS, 32'hC);
    read_check("w1c_status", REG_STATUS, 32'h2);
    check_rx("ovf_rx");
    read_check("ovf_status_clr", REG_STATUS, 32'h0);

    // Interrupt timing.
    cfg(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 8, 0);
    exp_q.push_back(32'h81);
    ahb_write(REG_TXDATA, 32'h81);
    step(17);
    check("irq_before_done", 32'(IRQ), 32'd0);
    step(1);
    check("irq_at_done", 32'(IRQ), 32'd1);
    check_rx("irq_rx");
    check("irq_after_read", 32'(IRQ), 32'd0);

    // Asynchronous reset in the middle of SHIFT.
    cfg(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 16, 3);
    ahb_write(REG_TXDATA, 32'hBEEF);
    for (int i = 0; i < 40 && SCLK !== 1'b1; i++) step(1);
    check("mid_sclk_high", 32'(SCLK), 32'd1);
    check("mid_state_shift", 32'(dbg_state), 32'(S_SHIFT));
    #2;
    HRESETn = 1'b0;
    #1;
    check("arst_sclk", 32'(SCLK), 32'd0);
    check("arst_cs_n", 32'(CS_n), 32'hF);
    check("arst_mosi", 32'(MOSI), 32'd0);
    check("arst_state", 32'(dbg_state), 32'(S_IDLE));
    step(1);
    HRESETn = 1'b1;
    step(1);
    read_check("arst_status", REG_STATUS, 32'h0);
    ahb_read(REG_RXDATA, d);
    check("arst_rxdata", d, 32'h0);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
